fetch_stage: RTL and testbench

Upstream neighbour of the instruction memory in the LEGv8 core. Owns the program counter and drives pc_addr into the combinational, big-endian instruction memory. Captures the returned 32b instruction into the IF/ID pipeline register with valid, stall, flush and branch-redirect control. Halts cleanly when the PC runs past the end of instruction memory.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage_if_id_reg.sv | 24 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 fetch stage and its IF/ID register.
package fetch_stage_pkg;

  localparam int unsigned PC_W        = 64;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t IDLE = 2'd0;
  localparam fetch_state_t RUN  = 2'd1;
  localparam fetch_state_t HALT = 2'd2;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_EMPTY = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] pc_addr;
  logic [31:0] imem_instruction;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_instruction,
    output pc_addr, if_id_valid, if_id_pc, if_id_instruction, halted, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_instruction,
    input  pc_addr, if_id_valid, if_id_pc, if_id_instruction, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with flush (highest priority), hold and load controls.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= IF_ID_EMPTY;
    end else if (flush) begin
      q <= IF_ID_EMPTY;
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC ownership, IF/ID capture, redirect handling and end-of-memory halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [63:0] IMEM_BYTES = 64'd64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t     state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cap, flush, hold, cnt_inc;
  logic [63:0]      redir_pc;
  logic             redir_ok, pc_over;
  if_id_t           if_id_d, if_id_q;

  // Range checks are done in 65 bits so IMEM_BYTES near 2^64 cannot overflow.
  assign redir_pc = bus.redirect_target & ~64'd3;
  assign redir_ok = ({1'b0, redir_pc} + 65'(INSTR_BYTES)) <= {1'b0, IMEM_BYTES};
  assign pc_over  = ({1'b0, pc_q} + 65'(INSTR_BYTES)) > {1'b0, IMEM_BYTES};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    cap      = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        if (bus.redirect_valid) pc_d = redir_pc;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d  = redir_pc;
          flush = 1'b1;
        end else if (bus.stall) begin
          hold = 1'b1;
        end else if (pc_over) begin
          state_d  = HALT;
          halted_d = 1'b1;
          flush    = 1'b1;
        end else begin
          cap     = 1'b1;
          cnt_inc = 1'b1;
          pc_d    = pc_q + 64'(INSTR_BYTES);
        end
      end
      HALT: begin
        if (bus.redirect_valid && redir_ok) begin
          pc_d     = redir_pc;
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        halted_d = 1'b0;
      end
    endcase
  end

  assign if_id_d = '{valid: 1'b1, pc: pc_q, instr: bus.imem_instruction};

  fetch_stage_if_id_reg u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .flush (flush),
    .load  (cap),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.pc_addr           = pc_q;
  assign bus.if_id_valid       = if_id_q.valid;
  assign bus.if_id_pc          = if_id_q.pc;
  assign bus.if_id_instruction = if_id_q.instr;
  assign bus.halted            = halted_q;
  assign bus.fetch_count       = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage with a 16-word instruction memory model.
module tb_fetch_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] exp_pc;
  exp_t sb[$];

  logic [31:0] mem [16] = '{
    32'hF8400182, 32'hF84001A3, 32'hAA010285, 32'h8A1B0386,
    32'h8B0300A4, 32'hCB040105, 32'hF80001C6, 32'hB4000067,
    32'h14000002, 32'hCB03012B, 32'h8B0A014C, 32'hF800018D,
    32'hAA0D01CE, 32'h8A0E01EF, 32'hF8000210, 32'h00000000
  };

  fetch_stage_if #(.CNT_W(32)) bus ();

  fetch_stage #(
    .RESET_PC   (64'd0),
    .IMEM_BYTES (64'd64),
    .CNT_W      (32)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_instruction = (bus.pc_addr < 64'd64) ? mem[bus.pc_addr[5:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected capture, advance one edge, then pop and compare IF/ID.
  task automatic fetch_edge();
    exp_t e;
    sb.push_back('{pc: exp_pc, instr: mem[exp_pc[5:2]]});
    tick();
    e = sb.pop_front();
    chk("cap_valid", 64'(bus.if_id_valid), 64'd1);
    chk("cap_pc", bus.if_id_pc, e.pc);
    chk("cap_instr", 64'(bus.if_id_instruction), 64'(e.instr));
    chk("cap_next_pc", bus.pc_addr, e.pc + 64'd4);
    exp_pc = exp_pc + 64'd4;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 64'd0;
    exp_pc              = 64'd0;
    #2;
    chk("rst_pc", bus.pc_addr, 64'd0);
    chk("rst_valid", 64'(bus.if_id_valid), 64'd0);
    chk("rst_if_pc", bus.if_id_pc, 64'd0);
    chk("rst_instr", 64'(bus.if_id_instruction), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_count", 64'(bus.fetch_count), 64'd0);
    #10 rst_n = 1'b1;

    // IDLE cycle: no capture
    tick();
    chk("idle_pc", bus.pc_addr, 64'd0);
    chk("idle_valid", 64'(bus.if_id_valid), 64'd0);

    exp_pc = 64'd0;
    fetch_edge();
    chk("first_instr", 64'(bus.if_id_instruction), 64'hF8400182);
    fetch_edge();
    chk("second_instr", 64'(bus.if_id_instruction), 64'hF84001A3);
    fetch_edge();
    chk("count_3", 64'(bus.fetch_count), 64'd3);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", bus.pc_addr, 64'd12);
      chk("stall_instr", 64'(bus.if_id_instruction), 64'hAA010285);
      chk("stall_count", 64'(bus.fetch_count), 64'd3);
    end
    bus.stall = 1'b0;
    fetch_edge();
    chk("post_stall_instr", 64'(bus.if_id_instruction), 64'h8A1B0386);
    for (int i = 0; i < 3; i++) fetch_edge();
    chk("pre_redir_pc", bus.pc_addr, 64'd28);
    chk("count_7", 64'(bus.fetch_count), 64'd7);

    // Redirect wins over stall and flushes IF/ID
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'd36;
    bus.stall           = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    chk("redir_pc", bus.pc_addr, 64'd36);
    chk("redir_valid", 64'(bus.if_id_valid), 64'd0);
    chk("redir_instr", 64'(bus.if_id_instruction), 64'd0);
    chk("redir_if_pc", bus.if_id_pc, 64'd0);
    chk("redir_count", 64'(bus.fetch_count), 64'd7);
    exp_pc = 64'd36;
    fetch_edge();
    chk("redir_capture", 64'(bus.if_id_instruction), 64'hCB03012B);
    chk("count_8", 64'(bus.fetch_count), 64'd8);

    // Asynchronous reset mid-cycle at pc_addr=40
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc_addr, 64'd0);
    chk("arst_valid", 64'(bus.if_id_valid), 64'd0);
    chk("arst_count", 64'(bus.fetch_count), 64'd0);
    chk("arst_halted", 64'(bus.halted), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("idle2_pc", bus.pc_addr, 64'd0);
    chk("idle2_valid", 64'(bus.if_id_valid), 64'd0);

    // Full sweep to the end of memory
    exp_pc = 64'd0;
    for (int i = 0; i < 16; i++) fetch_edge();
    chk("sweep_count", 64'(bus.fetch_count), 64'd16);
    chk("sweep_pc", bus.pc_addr, 64'd64);
    tick();
    chk("halt_halted", 64'(bus.halted), 64'd1);
    chk("halt_valid", 64'(bus.if_id_valid), 64'd0);
    chk("halt_count", 64'(bus.fetch_count), 64'd16);
    chk("halt_pc", bus.pc_addr, 64'd64);
    for (int i = 0; i < 5; i++) begin
      bus.stall = i[0];
      tick();
      chk("halt_hold_pc", bus.pc_addr, 64'd64);
      chk("halt_hold_halted", 64'(bus.halted), 64'd1);
    end
    bus.stall = 1'b0;

    // Out-of-range redirect is ignored in HALT
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'd100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("oor_halted", 64'(bus.halted), 64'd1);
    chk("oor_pc", bus.pc_addr, 64'd64);

    // Misaligned in-range redirect leaves HALT
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'd9;
    tick();
    bus.redirect_valid = 1'b0;
    chk("resume_halted", 64'(bus.halted), 64'd0);
    chk("resume_pc", bus.pc_addr, 64'd8);
    chk("resume_valid", 64'(bus.if_id_valid), 64'd0);
    exp_pc = 64'd8;
    fetch_edge();
    chk("resume_instr", 64'(bus.if_id_instruction), 64'hAA010285);
    chk("resume_count", 64'(bus.fetch_count), 64'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
